// File: rtl/ahb_lite_bus_monitor.sv
// Passive AHB-Lite monitor: pairs address and data phases into records queued in a FIFO.
// Define AHB_MON_PROTOCOL_CHECK_EN to build the burst tracker and sticky protocol-error flags.
module ahb_lite_bus_monitor #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [1:0]        HTRANS,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [ADDR_W-1:0] rec_addr,
   output logic              rec_write,
   output logic [2:0]        rec_size,
   output logic [2:0]        rec_burst,
   output logic [DATA_W-1:0] rec_data,
   output logic              rec_resp,
   output logic [CNT_W-1:0]  txn_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic              overflow,
   input  logic              err_clr,
   output logic              err_seq_start,
   output logic              err_addr,
   output logic              err_ctrl
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {ST_IDLE, ST_DATA} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              write;
      logic [2:0]        size;
      logic [2:0]        burst;
      logic [DATA_W-1:0] data;
      logic              resp;
   } rec_t;

   state_t            state;
   logic [ADDR_W-1:0] pend_addr;
   logic              pend_write;
   logic [2:0]        pend_size;
   logic [2:0]        pend_burst;

   rec_t              mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   rec_t              rec_in;
   rec_t              head;

   logic addr_accept;
   logic data_done;
   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic push_ok;
   logic drop;

   assign addr_accept = HREADY & HSEL & HTRANS[1];
   assign data_done   = (state == ST_DATA) & HREADY;
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop         = rec_valid & rec_ready;
   // A pop on the same edge frees the slot the push lands in, so full only blocks when not popping.
   assign push_ok     = data_done & (~fifo_full | pop);
   assign drop        = data_done & fifo_full & ~pop;

   always_comb begin
      rec_in.addr  = pend_addr;
      rec_in.write = pend_write;
      rec_in.size  = pend_size;
      rec_in.burst = pend_burst;
      rec_in.data  = pend_write ? HWDATA : HRDATA;
      rec_in.resp  = HRESP;
   end

   always_ff @(posedge HCLK) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= rec_in;
      end
   end

   assign head      = mem[rd_ptr[AW-1:0]];
   assign rec_valid = ~fifo_empty;
   assign rec_addr  = rec_valid ? head.addr  : '0;
   assign rec_write = rec_valid ? head.write : 1'b0;
   assign rec_size  = rec_valid ? head.size  : 3'd0;
   assign rec_burst = rec_valid ? head.burst : 3'd0;
   assign rec_data  = rec_valid ? head.data  : '0;
   assign rec_resp  = rec_valid ? head.resp  : 1'b0;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state      <= ST_IDLE;
         pend_addr  <= '0;
         pend_write <= 1'b0;
         pend_size  <= 3'd0;
         pend_burst <= 3'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         txn_count  <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         // A new address phase on the completing edge keeps the pipeline in DATA.
         if (addr_accept) begin
            state      <= ST_DATA;
            pend_addr  <= HADDR;
            pend_write <= HWRITE;
            pend_size  <= HSIZE;
            pend_burst <= HBURST;
         end else if (data_done) begin
            state <= ST_IDLE;
         end
         if (push_ok) begin
            wr_ptr    <= wr_ptr + 1'b1;
            txn_count <= txn_count + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop && (drop_count != {CNT_W{1'b1}})) begin
            drop_count <= drop_count + 1'b1;
         end
         if (err_clr) begin
            overflow <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef AHB_MON_PROTOCOL_CHECK_EN
   logic              trk_open;
   logic [ADDR_W-1:0] trk_addr;
   logic              trk_write;
   logic [2:0]        trk_size;
   logic [2:0]        trk_burst;
   logic [4:0]        trk_beats;
   logic [4:0]        burst_len;
   logic              trk_wrap;
   logic [ADDR_W-1:0] step_bytes;
   logic [ADDR_W-1:0] win_mask;
   logic [ADDR_W-1:0] next_lin;
   logic [ADDR_W-1:0] exp_addr;
   logic              seq_phase;
   logic              nonseq_phase;
   logic              idle_phase;

   // burst_len of 0 marks an unbounded INCR burst.
   always_comb begin
      burst_len = 5'd0;
      case (trk_burst)
         3'd0:       burst_len = 5'd1;
         3'd2, 3'd3: burst_len = 5'd4;
         3'd4, 3'd5: burst_len = 5'd8;
         3'd6, 3'd7: burst_len = 5'd16;
         default:    burst_len = 5'd0;
      endcase
   end

   assign trk_wrap     = (trk_burst == 3'd2) || (trk_burst == 3'd4) || (trk_burst == 3'd6);
   assign step_bytes   = ADDR_W'(1) << trk_size;
   assign win_mask     = (ADDR_W'(burst_len) << trk_size) - ADDR_W'(1);
   assign next_lin     = trk_addr + step_bytes;
   assign exp_addr     = trk_wrap ? ((trk_addr & ~win_mask) | (next_lin & win_mask)) : next_lin;
   assign seq_phase    = addr_accept & (HTRANS == 2'b11);
   assign nonseq_phase = addr_accept & (HTRANS == 2'b10);
   assign idle_phase   = HREADY & HSEL & (HTRANS == 2'b00);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         trk_open      <= 1'b0;
         trk_addr      <= '0;
         trk_write     <= 1'b0;
         trk_size      <= 3'd0;
         trk_burst     <= 3'd0;
         trk_beats     <= 5'd0;
         err_seq_start <= 1'b0;
         err_addr      <= 1'b0;
         err_ctrl      <= 1'b0;
      end else begin
         if (err_clr) begin
            err_seq_start <= 1'b0;
            err_addr      <= 1'b0;
            err_ctrl      <= 1'b0;
         end
         if (nonseq_phase) begin
            trk_open  <= 1'b1;
            trk_addr  <= HADDR;
            trk_write <= HWRITE;
            trk_size  <= HSIZE;
            trk_burst <= HBURST;
            trk_beats <= 5'd1;
         end else if (seq_phase) begin
            if (!trk_open || ((burst_len != 5'd0) && (trk_beats >= burst_len))) begin
               err_seq_start <= 1'b1;
            end
            if (trk_open && (HADDR != exp_addr)) begin
               err_addr <= 1'b1;
            end
            if (trk_open && ((HWRITE != trk_write) || (HSIZE != trk_size) || (HBURST != trk_burst))) begin
               err_ctrl <= 1'b1;
            end
            trk_addr <= HADDR;
            if (trk_beats != 5'd31) begin
               trk_beats <= trk_beats + 5'd1;
            end
         end else if (idle_phase) begin
            trk_open <= 1'b0;
         end
      end
   end
`else
   assign err_seq_start = 1'b0;
   assign err_addr      = 1'b0;
   assign err_ctrl      = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_bus_monitor.sv
// Directed bench for ahb_lite_bus_monitor; protocol-flag expectations follow AHB_MON_PROTOCOL_CHECK_EN.
module tb_ahb_lite_bus_monitor;

   logic        HCLK;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic        rec_valid;
   logic        rec_ready;
   logic [31:0] rec_addr;
   logic        rec_write;
   logic [2:0]  rec_size;
   logic [2:0]  rec_burst;
   logic [31:0] rec_data;
   logic        rec_resp;
   logic [15:0] txn_count;
   logic [15:0] drop_count;
   logic        overflow;
   logic        err_clr;
   logic        err_seq_start;
   logic        err_addr;
   logic        err_ctrl;

   int compared   = 0;
   int mismatched = 0;

`ifdef AHB_MON_PROTOCOL_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   ahb_lite_bus_monitor #(
      .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(8), .CNT_W(16)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP), .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_addr(rec_addr), .rec_write(rec_write), .rec_size(rec_size), .rec_burst(rec_burst),
      .rec_data(rec_data), .rec_resp(rec_resp), .txn_count(txn_count), .drop_count(drop_count),
      .overflow(overflow), .err_clr(err_clr), .err_seq_start(err_seq_start),
      .err_addr(err_addr), .err_ctrl(err_ctrl)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   // One bus cycle with word-sized transfers; the edge that ends it is the sampling edge.
   task automatic drive(input logic [1:0] trans, input logic [31:0] addr, input logic write,
                        input logic [2:0] burst, input logic [31:0] wdata, input logic ready);
      HSEL   = 1'b1;
      HTRANS = trans;
      HADDR  = addr;
      HWRITE = write;
      HSIZE  = 3'd2;
      HBURST = burst;
      HWDATA = wdata;
      HREADY = ready;
      step();
   endtask

   task automatic pop_check(input logic [31:0] addr, input logic write, input logic [31:0] data,
                            input logic resp);
      check("head_valid", 64'(rec_valid), 64'(1'b1));
      check("head_addr", 64'(rec_addr), 64'(addr));
      check("head_write", 64'(rec_write), 64'(write));
      check("head_data", 64'(rec_data), 64'(data));
      check("head_resp", 64'(rec_resp), 64'(resp));
      $display("record addr=%08h write=%0d data=%08h resp=%0d", rec_addr, rec_write, rec_data, rec_resp);
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
   endtask

   task automatic clear_flags();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   initial begin
      HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0; HBURST = 3'd0;
      HTRANS = 2'd0; HWDATA = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
      rec_ready = 1'b0; err_clr = 1'b0;
      #1;
      check("rst_valid", 64'(rec_valid), 64'(0));
      check("rst_txn", 64'(txn_count), 64'(0));
      check("rst_drop", 64'(drop_count), 64'(0));
      check("rst_ovf", 64'(overflow), 64'(0));
      check("rst_errs", 64'({err_seq_start, err_addr, err_ctrl}), 64'(0));
      step(); step();
      HRESET = 1'b0;

      // single write
      drive(2'd2, 32'h100, 1'b1, 3'd0, 32'h0, 1'b1);
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'hDEADBEEF, 1'b1);
      check("wr_txn", 64'(txn_count), 64'(1));
      pop_check(32'h100, 1'b1, 32'hDEADBEEF, 1'b0);
      check("wr_popped", 64'(rec_valid), 64'(0));

      // read with two wait states
      drive(2'd2, 32'h104, 1'b0, 3'd0, 32'h0, 1'b1);
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      check("rd_wait1", 64'(rec_valid), 64'(0));
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      check("rd_wait2", 64'(rec_valid), 64'(0));
      HRDATA = 32'h12345678;
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
      HRDATA = 32'h0;
      check("rd_txn", 64'(txn_count), 64'(2));
      pop_check(32'h104, 1'b0, 32'h12345678, 1'b0);

      // well-formed INCR4
      drive(2'd2, 32'h200, 1'b1, 3'd3, 32'h0, 1'b1);
      drive(2'd3, 32'h204, 1'b1, 3'd3, 32'hA0, 1'b1);
      drive(2'd3, 32'h208, 1'b1, 3'd3, 32'hA1, 1'b1);
      drive(2'd3, 32'h20C, 1'b1, 3'd3, 32'hA2, 1'b1);
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'hA3, 1'b1);
      check("incr4_txn", 64'(txn_count), 64'(6));
      check("incr4_errs", 64'({err_seq_start, err_addr, err_ctrl}), 64'(0));
      for (int k = 0; k < 4; k++) begin
         pop_check(32'h200 + 32'(4 * k), 1'b1, 32'hA0 + 32'(k), 1'b0);
      end

      // INCR4 with a skipped third address
      drive(2'd2, 32'h200, 1'b1, 3'd3, 32'h0, 1'b1);
      drive(2'd3, 32'h204, 1'b1, 3'd3, 32'hB0, 1'b1);
      drive(2'd3, 32'h20C, 1'b1, 3'd3, 32'hB1, 1'b1);
      drive(2'd3, 32'h210, 1'b1, 3'd3, 32'hB2, 1'b1);
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'hB3, 1'b1);
      check("bad_addr_flag", 64'(err_addr), 64'(EXP_ERR));
      check("bad_addr_other", 64'({err_seq_start, err_ctrl}), 64'(0));
      check("bad_addr_txn", 64'(txn_count), 64'(10));
      pop_check(32'h200, 1'b1, 32'hB0, 1'b0);
      pop_check(32'h204, 1'b1, 32'hB1, 1'b0);
      pop_check(32'h20C, 1'b1, 32'hB2, 1'b0);
      pop_check(32'h210, 1'b1, 32'hB3, 1'b0);
      clear_flags();
      check("clr_err_addr", 64'(err_addr), 64'(0));

      // WRAP4 word burst wrapping at the 16-byte window base 0x230
      drive(2'd2, 32'h238, 1'b1, 3'd2, 32'h0, 1'b1);
      drive(2'd3, 32'h23C, 1'b1, 3'd2, 32'hC0, 1'b1);
      drive(2'd3, 32'h230, 1'b1, 3'd2, 32'hC1, 1'b1);
      drive(2'd3, 32'h234, 1'b1, 3'd2, 32'hC2, 1'b1);
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'hC3, 1'b1);
      check("wrap4_errs", 64'({err_seq_start, err_addr, err_ctrl}), 64'(0));
      pop_check(32'h238, 1'b1, 32'hC0, 1'b0);
      pop_check(32'h23C, 1'b1, 32'hC1, 1'b0);
      pop_check(32'h230, 1'b1, 32'hC2, 1'b0);
      pop_check(32'h234, 1'b1, 32'hC3, 1'b0);

      // SEQ with no open burst
      drive(2'd3, 32'h400, 1'b0, 3'd1, 32'h0, 1'b1);
      HRDATA = 32'h55;
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
      HRDATA = 32'h0;
      check("lone_seq_flag", 64'(err_seq_start), 64'(EXP_ERR));
      check("lone_seq_other", 64'({err_addr, err_ctrl}), 64'(0));
      pop_check(32'h400, 1'b0, 32'h55, 1'b0);
      clear_flags();
      check("clr_seq", 64'(err_seq_start), 64'(0));
      check("seq_txn", 64'(txn_count), 64'(15));

      // two-cycle ERROR response
      drive(2'd2, 32'h300, 1'b1, 3'd0, 32'h0, 1'b1);
      HRESP = 1'b1;
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'h77, 1'b0);
      check("err_first", 64'(rec_valid), 64'(0));
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'h77, 1'b1);
      HRESP = 1'b0;
      check("err_txn", 64'(txn_count), 64'(16));
      pop_check(32'h300, 1'b1, 32'h77, 1'b1);
      check("err_single", 64'(rec_valid), 64'(0));

      // nine writes into an eight-deep FIFO with no consumer
      for (int i = 0; i < 9; i++) begin
         drive(2'd2, 32'h500 + 32'(4 * i), 1'b1, 3'd0, 32'hDF + 32'(i), 1'b1);
      end
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'hE8, 1'b1);
      check("ovf_txn", 64'(txn_count), 64'(24));
      check("ovf_drop", 64'(drop_count), 64'(1));
      check("ovf_flag", 64'(overflow), 64'(1));
      check("ovf_head", 64'(rec_addr), 64'(32'h500));
      clear_flags();
      check("ovf_clr", 64'(overflow), 64'(0));
      check("ovf_drop_kept", 64'(drop_count), 64'(1));

      // push and pop on the same edge while full
      drive(2'd2, 32'h600, 1'b1, 3'd0, 32'h0, 1'b1);
      rec_ready = 1'b1;
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'hF0, 1'b1);
      rec_ready = 1'b0;
      check("full_pp_txn", 64'(txn_count), 64'(25));
      check("full_pp_drop", 64'(drop_count), 64'(1));
      check("full_pp_ovf", 64'(overflow), 64'(0));
      for (int k = 1; k < 8; k++) begin
         pop_check(32'h500 + 32'(4 * k), 1'b1, 32'hE0 + 32'(k), 1'b0);
      end
      pop_check(32'h600, 1'b1, 32'hF0, 1'b0);
      check("drained", 64'(rec_valid), 64'(0));

      // reset during a waited data phase
      drive(2'd2, 32'h700, 1'b0, 3'd0, 32'h0, 1'b1);
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
      HRESET = 1'b1;
      #1;
      check("mid_rst_txn", 64'(txn_count), 64'(0));
      check("mid_rst_drop", 64'(drop_count), 64'(0));
      step();
      HRESET = 1'b0;
      HRDATA = 32'h99;
      drive(2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1);
      check("mid_rst_valid", 64'(rec_valid), 64'(0));
      check("mid_rst_txn2", 64'(txn_count), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
